// File: rtl/iob_axistream_tx.sv
// CPU-writable byte FIFO feeding an AXI-Stream master through one output register.
// Optional frame counter compiled in with IOB_AXISTREAM_TX_FRAME_CNT_EN.
module iob_axistream_tx #(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 3,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic [7:0]          tdata,
  output logic                tvalid,
  input  logic                tready,
  output logic                tlast
);

  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int LW    = FIFO_DEPTH_LOG2 + 1;

  localparam logic [ADDR_W-1:0] ADDR_DATA      = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_DATA_LAST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_STATUS    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_LEVEL     = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ADDR_SOFTRESET = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ADDR_FRAMES    = ADDR_W'(5);

  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

  logic [8:0]        mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [7:0]        tdata_q, tdata_d;
  logic              tlast_q, tlast_d;
  logic              tvalid_q, tvalid_d;
  logic [DATA_W-1:0] frames_s;

  logic       req_acc_s, wr_acc_s, rd_acc_s;
  logic       push_req_s, push_s, pop_s, flush_s, handshake_s;
  logic       full_s, empty_s;
  logic [8:0] head_s;
  logic       unused_s;

  // A request is accepted only when ready is low, giving one request per two cycles.
  assign req_acc_s   = valid & ~ready_q;
  assign wr_acc_s    = req_acc_s & (|wstrb);
  assign rd_acc_s    = req_acc_s & ~(|wstrb);
  assign push_req_s  = wr_acc_s & ((address == ADDR_DATA) | (address == ADDR_DATA_LAST));
  assign flush_s     = wr_acc_s & (address == ADDR_SOFTRESET) & wdata[0];
  assign full_s      = (level_q == LVL_MAX);
  assign empty_s     = (level_q == {LW{1'b0}});
  assign push_s      = push_req_s & ~full_s;
  assign pop_s       = ~empty_s & (~tvalid_q | tready);
  assign handshake_s = tvalid_q & tready;
  assign head_s      = mem_q[rd_ptr_q];
  assign unused_s    = ^wdata[DATA_W-1:8];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    tdata_d    = tdata_q;
    tlast_d    = tlast_q;
    tvalid_d   = tvalid_q;
    if (flush_s) begin
      wr_ptr_d   = {PW{1'b0}};
      rd_ptr_d   = {PW{1'b0}};
      level_d    = {LW{1'b0}};
      overflow_d = 1'b0;
      tdata_d    = 8'h00;
      tlast_d    = 1'b0;
      tvalid_d   = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (push_req_s & full_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
      // The output stage refills from the head whenever it is empty or being drained.
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        tdata_d  = head_s[8:1];
        tlast_d  = head_s[0];
        tvalid_d = 1'b1;
      end else if (handshake_s) begin
        rd_ptr_d = rd_ptr_q;
        tvalid_d = 1'b0;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  always_comb begin
    ready_d = req_acc_s;
    rdata_d = {DATA_W{1'b0}};
    if (rd_acc_s) begin
      case (address)
        ADDR_STATUS: rdata_d = {{(DATA_W-3){1'b0}}, overflow_q, full_s, empty_s};
        ADDR_LEVEL:  rdata_d = DATA_W'(level_q);
        ADDR_FRAMES: rdata_d = frames_s;
        default:     rdata_d = {DATA_W{1'b0}};
      endcase
    end else begin
      rdata_d = {DATA_W{1'b0}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      level_q    <= {LW{1'b0}};
      overflow_q <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= {DATA_W{1'b0}};
      tdata_q    <= 8'h00;
      tlast_q    <= 1'b0;
      tvalid_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
      tvalid_q   <= tvalid_d;
    end
  end

  // Storage array carries no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {wdata[7:0], (address == ADDR_DATA_LAST)};
    end
  end

`ifdef IOB_AXISTREAM_TX_FRAME_CNT_EN
  logic [DATA_W-1:0] frames_q, frames_d;

  always_comb begin
    frames_d = frames_q;
    if (flush_s) begin
      frames_d = {DATA_W{1'b0}};
    end else if (handshake_s & tlast_q) begin
      frames_d = frames_q + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      frames_d = frames_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frames_q <= {DATA_W{1'b0}};
    end else begin
      frames_q <= frames_d;
    end
  end

  assign frames_s = frames_q;
`else
  assign frames_s = {DATA_W{1'b0}};
`endif

  assign ready  = ready_q;
  assign rdata  = rdata_q;
  assign tdata  = tdata_q;
  assign tlast  = tlast_q;
  assign tvalid = tvalid_q;

endmodule
